// File: rtl/rr_arbiter_4.sv
// -----------------------------------------------------------------------------
// rr_arbiter_4
//
// Four-way round-robin arbiter. It shares one resource between four
// requesters and drives registered, active-low one-hot select lines in the
// 2-to-4 decoder convention (idx 0 -> 1110 ... idx 3 -> 0111, idle -> 1111).
//
// Fairness comes from two mechanisms:
//   - A rotating priority pointer. Every grant exit moves the pointer past
//     the grantee.
//   - A hold limit. A grant is revoked after MAX_HOLD consecutive cycles.
// Every handover passes through at least one all-ones cycle, so two select
// lines can never be low at the same time (break-before-make).
//
// Parameters
//   MAX_HOLD   maximum consecutive cycles a single grant may be held (2..256)
//
// Ports
//   clk        system clock, rising-edge active
//   reset      asynchronous, active-high reset
//   en         global enable; 0 blocks new grants and drops a live grant
//   req[3:0]   active-high requests, held while the requester needs the bus
//   grant_n    active-low one-hot grant (registered)
//   grant_idx  index of the current or most recent grantee (registered)
//   busy       high while any grant_n bit is low (registered)
//   timeout    one-cycle pulse in the IDLE cycle that follows a hold expiry
// -----------------------------------------------------------------------------
module rr_arbiter_4 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] grant_n,
    output logic [1:0] grant_idx,
    output logic       busy,
    output logic       timeout
);

    // Hold counter width is ceil(log2(MAX_HOLD)). The counter runs
    // 0..MAX_HOLD-1 while a grant is live.
    localparam int CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);

    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
            $error("rr_arbiter_4: MAX_HOLD must be in the range 2..256");
        end
    endgenerate

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Registered state
    logic [0:0]       state_q;
    logic [1:0]       ptr_q;
    logic [CNT_W-1:0] cnt_q;

    // Next-state values
    logic [0:0]       state_d;
    logic [1:0]       ptr_d;
    logic [CNT_W-1:0] cnt_d;
    logic [1:0]       idx_d;
    logic             timeout_d;
    logic [3:0]       grant_n_d;
    logic             busy_d;

    logic [1:0]       winner;

    // Round-robin pick: the first set request found when scanning
    // ptr, ptr+1, ptr+2, ptr+3 (mod 4). The loop walks from the largest
    // offset down to offset 0, so the smallest offset is assigned last
    // and therefore wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] r,
                                           input logic [1:0] p);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    // 2-to-4 active-low decode.
    function automatic logic [3:0] decode_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    assign winner = rr_pick(req, ptr_q);

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        idx_d     = grant_idx;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en && (req != 4'b0000)) begin
                    state_d = ST_GRANT;
                    idx_d   = winner;
                    cnt_d   = '0;
                end
            end

            ST_GRANT: begin
                // Priority order: disable, then voluntary release, then
                // expiry. Release and expiry on the same edge count as a
                // release, so no timeout pulse is raised.
                if (!en || !req[grant_idx]) begin
                    state_d = ST_IDLE;
                    ptr_d   = grant_idx + 2'd1;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    ptr_d     = grant_idx + 2'd1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The outputs are derived from the next state and registered with
        // it, so no combinational path reaches a port from req or en.
        grant_n_d = (state_d == ST_GRANT) ? decode_n(idx_d) : 4'b1111;
        busy_d    = (state_d == ST_GRANT);
    end

    // NOTE: sequential state uses non-blocking assignments only. All
    // registers take a defined value on reset, so grant_n is never X and is
    // driven to 1111 as soon as reset is asserted, even mid-grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
            grant_idx <= 2'd0;
            grant_n   <= 4'b1111;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            grant_idx <= idx_d;
            grant_n   <= grant_n_d;
            busy      <= busy_d;
            timeout   <= timeout_d;
        end
    end

endmodule
